// File: rtl/cpu_ex_mem_reg.sv
// cpu_ex_mem_reg: EX -> MEM pipeline register for the CPU.
// Registers the ALU result and instruction metadata, owns the architectural
// flag register (OF, CF, ZF, NF), resolves conditional branches against the
// committed flags, squashes the single wrong-path instruction after a taken
// branch, and honours downstream stall and external flush.
// Optional feature: define CPU_EX_PERF_CNT_EN to add the perf_retired and
// perf_br_taken event counters and their output ports.
module cpu_ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [7:0]        ex_op,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_of,
    input  logic              alu_cf,
    input  logic              alu_zf,
    input  logic              alu_nf,
    input  logic              alu_of_en,
    input  logic              alu_cf_en,
    input  logic              alu_zf_en,
    input  logic              alu_nf_en,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [7:0]        mem_op,
    output logic [RD_W-1:0]   mem_rd,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic              flag_of,
    output logic              flag_cf,
    output logic              flag_zf,
    output logic              flag_nf,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target
`ifdef CPU_EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_br_taken
`endif
);

    // Branch / jump opcodes (ALU opcode encoding)
    localparam logic [7:0] OP_BNEQ = 8'h33;
    localparam logic [7:0] OP_BLTZ = 8'h35;
    localparam logic [7:0] OP_BGTZ = 8'h37;
    localparam logic [7:0] OP_BLEZ = 8'h39;
    localparam logic [7:0] OP_BGEZ = 8'h3B;
    localparam logic [7:0] OP_JMP  = 8'h3D;
    localparam logic [7:0] OP_JMPI = 8'h3F;

    // State registers
    logic              mem_valid_r;
    logic [7:0]        mem_op_r;
    logic [RD_W-1:0]   mem_rd_r;
    logic [DATA_W-1:0] mem_result_r;
    logic [DATA_W-1:0] mem_store_data_r;
    logic              flag_of_r;
    logic              flag_cf_r;
    logic              flag_zf_r;
    logic              flag_nf_r;
    logic              br_taken_r;
    logic [DATA_W-1:0] br_target_r;
    logic              squash_r;

    // Next-state and control signals
    logic              advance_s;
    logic              xfer_s;
    logic              kill_s;
    logic              cond_s;
    logic              br_hit_s;
    logic              mem_valid_nxt_s;
    logic              squash_nxt_s;
    logic              flag_of_nxt_s;
    logic              flag_cf_nxt_s;
    logic              flag_zf_nxt_s;
    logic              flag_nf_nxt_s;
    logic [DATA_W-1:0] br_target_nxt_s;

    assign ex_ready = !mem_stall;

    // Classify the EX slot and resolve the branch condition on committed flags
    always_comb begin
        advance_s = !mem_stall && !flush;
        xfer_s    = ex_valid && advance_s && !squash_r;
        kill_s    = ex_valid && advance_s && squash_r;
        cond_s    = 1'b0;
        case (ex_op)
            OP_BNEQ: cond_s = !flag_zf_r;
            OP_BLTZ: cond_s = flag_nf_r;
            OP_BGTZ: cond_s = !flag_nf_r && !flag_zf_r;
            OP_BLEZ: cond_s = flag_nf_r || flag_zf_r;
            OP_BGEZ: cond_s = !flag_nf_r;
            OP_JMP:  cond_s = 1'b1;
            OP_JMPI: cond_s = 1'b1;
            default: cond_s = 1'b0;
        endcase
        br_hit_s = xfer_s && cond_s;
    end

    // Next-state for MEM valid, squash, flags and branch target
    always_comb begin
        mem_valid_nxt_s = mem_valid_r;
        squash_nxt_s    = squash_r;
        if (flush) begin
            mem_valid_nxt_s = 1'b0;
            squash_nxt_s    = 1'b0;
        end else if (mem_stall) begin
            mem_valid_nxt_s = mem_valid_r;
            squash_nxt_s    = squash_r;
        end else if (xfer_s) begin
            mem_valid_nxt_s = 1'b1;
            squash_nxt_s    = br_hit_s;
        end else if (kill_s) begin
            mem_valid_nxt_s = 1'b0;
            squash_nxt_s    = 1'b0;
        end else begin
            mem_valid_nxt_s = 1'b0;
            squash_nxt_s    = squash_r;
        end

        flag_of_nxt_s = (xfer_s && alu_of_en) ? alu_of : flag_of_r;
        flag_cf_nxt_s = (xfer_s && alu_cf_en) ? alu_cf : flag_cf_r;
        flag_zf_nxt_s = (xfer_s && alu_zf_en) ? alu_zf : flag_zf_r;
        flag_nf_nxt_s = (xfer_s && alu_nf_en) ? alu_nf : flag_nf_r;

        if (br_hit_s) begin
            br_target_nxt_s = alu_out;
        end else begin
            br_target_nxt_s = br_target_r;
        end
    end

    // Control and flag state; br_taken is a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_r <= 1'b0;
            squash_r    <= 1'b0;
            flag_of_r   <= 1'b0;
            flag_cf_r   <= 1'b0;
            flag_zf_r   <= 1'b0;
            flag_nf_r   <= 1'b0;
            br_taken_r  <= 1'b0;
            br_target_r <= {DATA_W{1'b0}};
        end else begin
            mem_valid_r <= mem_valid_nxt_s;
            squash_r    <= squash_nxt_s;
            flag_of_r   <= flag_of_nxt_s;
            flag_cf_r   <= flag_cf_nxt_s;
            flag_zf_r   <= flag_zf_nxt_s;
            flag_nf_r   <= flag_nf_nxt_s;
            br_taken_r  <= br_hit_s;
            br_target_r <= br_target_nxt_s;
        end
    end

    // MEM payload: loads only on a transfer, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_op_r         <= 8'h00;
            mem_rd_r         <= {RD_W{1'b0}};
            mem_result_r     <= {DATA_W{1'b0}};
            mem_store_data_r <= {DATA_W{1'b0}};
        end else if (xfer_s) begin
            mem_op_r         <= ex_op;
            mem_rd_r         <= ex_rd;
            mem_result_r     <= alu_out;
            mem_store_data_r <= ex_store_data;
        end else begin
            mem_op_r         <= mem_op_r;
            mem_rd_r         <= mem_rd_r;
            mem_result_r     <= mem_result_r;
            mem_store_data_r <= mem_store_data_r;
        end
    end

    assign mem_valid      = mem_valid_r;
    assign mem_op         = mem_op_r;
    assign mem_rd         = mem_rd_r;
    assign mem_result     = mem_result_r;
    assign mem_store_data = mem_store_data_r;
    assign flag_of        = flag_of_r;
    assign flag_cf        = flag_cf_r;
    assign flag_zf        = flag_zf_r;
    assign flag_nf        = flag_nf_r;
    assign br_taken       = br_taken_r;
    assign br_target      = br_target_r;

`ifdef CPU_EX_PERF_CNT_EN
    logic [31:0] perf_retired_r;
    logic [31:0] perf_br_taken_r;

    // Event counters for retired transfers and taken branches (wrap mod 2^32)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired_r  <= 32'd0;
            perf_br_taken_r <= 32'd0;
        end else begin
            perf_retired_r  <= xfer_s   ? (perf_retired_r + 32'd1)  : perf_retired_r;
            perf_br_taken_r <= br_hit_s ? (perf_br_taken_r + 32'd1) : perf_br_taken_r;
        end
    end

    assign perf_retired  = perf_retired_r;
    assign perf_br_taken = perf_br_taken_r;
`endif

endmodule

// File: tb/tb_cpu_ex_mem_reg.sv
// Scoreboard bench for cpu_ex_mem_reg: the driver applies one EX slot per
// cycle, a transaction-level reference model predicts the post-edge view and
// queues it; a separate monitor pops and compares after every rising edge.
`timescale 1ns/1ps
module tb_cpu_ex_mem_reg;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_valid = 1'b0;
    logic              ex_ready;
    logic [7:0]        ex_op = 8'h00;
    logic [RD_W-1:0]   ex_rd = '0;
    logic [DATA_W-1:0] ex_store_data = '0;
    logic [DATA_W-1:0] alu_out = '0;
    logic              alu_of = 1'b0, alu_cf = 1'b0, alu_zf = 1'b0, alu_nf = 1'b0;
    logic              alu_of_en = 1'b0, alu_cf_en = 1'b0, alu_zf_en = 1'b0, alu_nf_en = 1'b0;
    logic              mem_stall = 1'b0;
    logic              flush = 1'b0;
    logic              mem_valid;
    logic [7:0]        mem_op;
    logic [RD_W-1:0]   mem_rd;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] mem_store_data;
    logic              flag_of, flag_cf, flag_zf, flag_nf;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;
`ifdef CPU_EX_PERF_CNT_EN
    logic [31:0]       perf_retired;
    logic [31:0]       perf_br_taken;
`endif

    always #5 clk = ~clk;

    cpu_ex_mem_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_store_data(ex_store_data), .alu_out(alu_out),
        .alu_of(alu_of), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_nf(alu_nf),
        .alu_of_en(alu_of_en), .alu_cf_en(alu_cf_en), .alu_zf_en(alu_zf_en), .alu_nf_en(alu_nf_en),
        .mem_stall(mem_stall), .flush(flush), .mem_valid(mem_valid), .mem_op(mem_op),
        .mem_rd(mem_rd), .mem_result(mem_result), .mem_store_data(mem_store_data),
        .flag_of(flag_of), .flag_cf(flag_cf), .flag_zf(flag_zf), .flag_nf(flag_nf),
        .br_taken(br_taken), .br_target(br_target)
`ifdef CPU_EX_PERF_CNT_EN
        , .perf_retired(perf_retired), .perf_br_taken(perf_br_taken)
`endif
    );

    typedef struct {
        logic        valid;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] sd;
        logic [3:0]  flags;   // {OF, CF, ZF, NF}
        logic        brt;
        logic [31:0] tgt;
        logic [31:0] n_ret;
        logic [31:0] n_br;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: architectural state seen by the downstream stage
    exp_t m;
    logic m_squash_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic branch_taken(input logic [7:0] op, input logic [3:0] fl);
        logic z, n;
        z = fl[1];
        n = fl[0];
        case (op)
            8'h33:        return !z;
            8'h35:        return n;
            8'h37:        return !n && !z;
            8'h39:        return n || z;
            8'h3B:        return !n;
            8'h3D, 8'h3F: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m = '{valid: 1'b0, op: 8'h00, rd: 5'd0, res: 32'd0, sd: 32'd0, flags: 4'h0,
              brt: 1'b0, tgt: 32'd0, n_ret: 32'd0, n_br: 32'd0};
        m_squash_pending = 1'b0;
    endtask

    // One EX slot: apply inputs, predict the post-edge view, queue it
    task automatic drive(input logic v, input logic [7:0] op, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [3:0] fl, input logic [3:0] en,
                         input logic st, input logic fs);
        logic tk;
        @(negedge clk);
        ex_valid = v; ex_op = op; ex_rd = rd; alu_out = alu; ex_store_data = sd;
        {alu_of, alu_cf, alu_zf, alu_nf} = fl;
        {alu_of_en, alu_cf_en, alu_zf_en, alu_nf_en} = en;
        mem_stall = st; flush = fs;
        m.brt = 1'b0;
        if (fs) begin
            m.valid = 1'b0;
            m_squash_pending = 1'b0;
        end else if (st) begin
            // downstream holds everything it already has
        end else if (!v) begin
            m.valid = 1'b0;
        end else if (m_squash_pending) begin
            m.valid = 1'b0;
            m_squash_pending = 1'b0;
        end else begin
            tk = branch_taken(op, m.flags);
            m.valid = 1'b1; m.op = op; m.rd = rd; m.res = alu; m.sd = sd;
            m.flags = (m.flags & ~en) | (fl & en);
            m.n_ret = m.n_ret + 32'd1;
            if (tk) begin
                m.brt = 1'b1; m.tgt = alu; m_squash_pending = 1'b1;
                m.n_br = m.n_br + 32'd1;
            end
        end
        sb_q.push_back(m);
        #1 check("ex_ready", {31'd0, ex_ready}, {31'd0, !st});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
        check({tag, "_mem_op"}, {24'd0, mem_op}, 32'd0);
        check({tag, "_mem_rd"}, {27'd0, mem_rd}, 32'd0);
        check({tag, "_mem_result"}, mem_result, 32'd0);
        check({tag, "_mem_store_data"}, mem_store_data, 32'd0);
        check({tag, "_flags"}, {28'd0, flag_of, flag_cf, flag_zf, flag_nf}, 32'd0);
        check({tag, "_br_taken"}, {31'd0, br_taken}, 32'd0);
        check({tag, "_br_target"}, br_target, 32'd0);
    endtask

    // Monitor: after every rising edge pop one prediction and compare
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("mem_valid", {31'd0, mem_valid}, {31'd0, e.valid});
                if (e.valid) begin
                    check("mem_op", {24'd0, mem_op}, {24'd0, e.op});
                    check("mem_rd", {27'd0, mem_rd}, {27'd0, e.rd});
                    check("mem_result", mem_result, e.res);
                    check("mem_store_data", mem_store_data, e.sd);
                end
                check("flags", {28'd0, flag_of, flag_cf, flag_zf, flag_nf}, {28'd0, e.flags});
                check("br_taken", {31'd0, br_taken}, {31'd0, e.brt});
                if (e.brt) check("br_target", br_target, e.tgt);
`ifdef CPU_EX_PERF_CNT_EN
                check("perf_retired", perf_retired, e.n_ret);
                check("perf_br_taken", perf_br_taken, e.n_br);
`endif
            end
        end
    end

    localparam logic [7:0] ADD = 8'h10, SUB = 8'h12, LDI = 8'h81;
    localparam logic [7:0] BNEQ = 8'h33, BLTZ = 8'h35, JMP = 8'h3D;

    initial begin : stimulus
        logic [7:0] ops [11];
        logic [7:0] op;
        logic       st, fs, v;
        int         budget;
        ops = '{8'h10, 8'h12, 8'h81, 8'h33, 8'h35, 8'h37, 8'h39, 8'h3B, 8'h3D, 8'h3F, 8'h00};
        model_reset();

        #2;
        check_outputs_zero("reset");
        #10;
        @(negedge clk);
        rst_n = 1'b1;

        // ADD producing zero: ZF set, NF untouched
        drive(1'b1, ADD, 5'd1, 32'h0000_0000, 32'h0, 4'b0010, 4'b0010, 1'b0, 1'b0);
        // BNEQ with ZF=1: not taken; following ADD registers normally
        drive(1'b1, BNEQ, 5'd0, 32'h0000_0100, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, ADD, 5'd2, 32'h0000_0011, 32'h22, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // Set NF (clear ZF), then BLTZ taken; next ADD squashed, the one after registers
        drive(1'b1, ADD, 5'd3, 32'h8000_0000, 32'h0, 4'b0001, 4'b0011, 1'b0, 1'b0);
        drive(1'b1, BLTZ, 5'd0, 32'h0000_2000, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, ADD, 5'd4, 32'h0000_0044, 32'h0, 4'b1111, 4'b1111, 1'b0, 1'b0);
        drive(1'b1, ADD, 5'd5, 32'h0000_0055, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // SUB held by a three-cycle stall, registered once on release
        repeat (3) drive(1'b1, SUB, 5'd6, 32'h0000_0066, 32'h77, 4'b1000, 4'b1000, 1'b1, 1'b0);
        drive(1'b1, SUB, 5'd6, 32'h0000_0066, 32'h77, 4'b1000, 4'b1000, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 5'd0, 32'h0, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // Taken JMP, then flush during stall clears the pending squash
        drive(1'b1, JMP, 5'd0, 32'h0000_4000, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, ADD, 5'd7, 32'h0000_0777, 32'h0, 4'b0000, 4'b0000, 1'b1, 1'b1);
        drive(1'b1, ADD, 5'd8, 32'h0000_0888, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // LDI with every enable low and every ALU flag high: flags hold
        drive(1'b1, LDI, 5'd9, 32'hB0B0_B0B0, 32'h0, 4'b1111, 4'b0000, 1'b0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            op = ops[$urandom_range(0, 10)];
            if (op == 8'h00) op = 8'($urandom);
            v  = ($urandom_range(0, 9) < 8);
            st = ($urandom_range(0, 4) == 0);
            fs = ($urandom_range(0, 15) == 0);
            drive(v, op, 5'($urandom), $urandom, $urandom, 4'($urandom), 4'($urandom), st, fs);
        end

        // Taken JMP, then asynchronous reset mid-cycle discards everything
        drive(1'b1, JMP, 5'd0, 32'h0000_9000, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0; mem_stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        sb_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // First transfer after reset is not squashed
        drive(1'b1, ADD, 5'd10, 32'h0000_0AAA, 32'h5, 4'b0100, 4'b0100, 1'b0, 1'b0);
        drive(1'b1, BLTZ, 5'd0, 32'h0000_3000, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 5'd0, 32'h0, 32'h0, 4'b0000, 4'b0000, 1'b0, 1'b0);

        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
